// File: rtl/recirc_pkg.sv
// Shared definitions for the recirculator / re-injector pair on the clk_2f domain.
// Both ends import this package so that word width, FIFO depth and the
// re-injector state encoding stay in agreement.
package recirc_pkg;

  // Default word width shared with the recirculator.
  localparam int RECIRC_DATA_W = 32;

  // Default re-injection FIFO depth (power of two, at least 2).
  localparam int RECIRC_DEPTH = 8;

  // Re-injector FSM states.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PASS    = 2'd2
  } state_t;

  // True when a pointer pair describes a completely full FIFO: the wrap bits
  // differ and the index bits match. Pointers are passed as 32-bit values so
  // the helper is independent of the FIFO depth.
  function automatic logic ptr_is_full(input logic [31:0] wr_ptr,
                                       input logic [31:0] rd_ptr,
                                       input int          aw);
    logic [31:0] w_diff;
    logic [31:0] w_msb;
    w_diff = wr_ptr ^ rd_ptr;
    w_msb  = 32'd1 << aw;
    return (w_diff == w_msb);
  endfunction

endpackage

// File: rtl/fifo_recirc.sv
// Single-clock FIFO for the re-injector backlog.
// Pointers are one bit wider than the index so full and empty can be told
// apart; they wrap modulo 2*DEPTH. A push into a full FIFO with no
// simultaneous pop is dropped and leaves the contents untouched. The head
// word is presented combinationally on rdata.
module fifo_recirc
  import recirc_pkg::*;
#(
  parameter  int DATA_W = RECIRC_DATA_W,
  parameter  int DEPTH  = RECIRC_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_rd_ptr;
  logic              w_wr_en;
  logic              w_rd_en;

  // Status decoded straight from the registered pointers.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = ptr_is_full(32'(r_wr_ptr), 32'(r_rd_ptr), AW);
  assign count = r_wr_ptr - r_rd_ptr;
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  // A push is accepted unless full; a pop in the same cycle frees the slot.
  assign w_wr_en = push && (!full || pop);
  assign w_rd_en = pop && !empty;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; reset discards the backlog by realigning both pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {CW{1'b0}};
      r_rd_ptr <= {CW{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

endmodule

// File: rtl/recirc_reinyector.sv
// Return end of the recirculation path. While the lane is inactive it stores
// words diverted by the recirculator; when the lane becomes active it replays
// them in order ahead of fresh input, then settles into a registered
// pass-through of the fresh stream once the backlog is empty.
module recirc_reinyector
  import recirc_pkg::*;
#(
  parameter  int DATA_W = RECIRC_DATA_W,
  parameter  int DEPTH  = RECIRC_DEPTH,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              active,
  input  logic [DATA_W-1:0] recirc_in,
  input  logic              recirc_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CW-1:0]     fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow
);

  state_t            r_state;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_push_ok;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_next;
  logic              w_full;
  logic              w_empty;

  fifo_recirc #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk_2f),
    .reset  (reset),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (w_wdata),
    .rdata  (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Push source: recirculated words while inactive, fresh words while the
  // backlog is still being collected or drained, nothing once passing through.
  always_comb begin
    w_push  = 1'b0;
    w_wdata = recirc_in;
    if (!active) begin
      w_push  = recirc_valid;
      w_wdata = recirc_in;
    end else if (r_state != ST_PASS) begin
      w_push  = valid_in;
      w_wdata = data_in;
    end else begin
      w_push  = 1'b0;
      w_wdata = data_in;
    end
  end

  // Pop gating and occupancy after this cycle's push and pop.
  always_comb begin
    w_pop        = (r_state == ST_DRAIN) && active && !w_empty;
    w_drop       = w_push && w_full && !w_pop;
    w_push_ok    = w_push && !w_drop;
    w_count_next = w_count + {{(CW-1){1'b0}}, w_push_ok}
                           - {{(CW-1){1'b0}}, w_pop};
  end

  // FSM with registered downstream word, qualifier and sticky overflow flag.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state     <= ST_COLLECT;
      r_data_out  <= {DATA_W{1'b0}};
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end

      case (r_state)
        ST_COLLECT: begin
          r_valid_out <= 1'b0;
          if (!active) begin
            r_state <= ST_COLLECT;
          end else if (w_count_next != {CW{1'b0}}) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_PASS;
          end
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_data_out  <= w_head;
            r_valid_out <= 1'b1;
          end else begin
            r_valid_out <= 1'b0;
          end
          if (!active) begin
            r_state <= ST_COLLECT;
          end else if (w_count_next == {CW{1'b0}}) begin
            r_state <= ST_PASS;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_PASS: begin
          r_data_out  <= data_in;
          r_valid_out <= valid_in;
          if (!active) begin
            r_state <= ST_COLLECT;
          end else begin
            r_state <= ST_PASS;
          end
        end
        default: begin
          r_valid_out <= 1'b0;
          r_state     <= ST_COLLECT;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign overflow   = r_overflow;
  assign fifo_count = w_count;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;

endmodule

// File: tb/tb_recirc_reinyector.sv
// Randomized self-checking bench for recirc_reinyector against a queue-based
// behavioural reference model, plus directed scenarios for the corner cases.
module tb_recirc_reinyector;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CW     = 4;

  localparam int M_COLLECT = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_PASS    = 2;

  logic              clk_2f = 1'b0;
  logic              reset;
  logic              active;
  logic [DATA_W-1:0] recirc_in;
  logic              recirc_valid;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;

  always #5 clk_2f = ~clk_2f;

  recirc_reinyector #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .active       (active),
    .recirc_in    (recirc_in),
    .recirc_valid (recirc_valid),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: backlog as a queue, mode, output regs, sticky flag.
  logic [DATA_W-1:0] m_q[$];
  int                m_mode = M_COLLECT;
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_vout = 1'b0;
  logic              m_ovf  = 1'b0;

  // Words observed with valid_out=1, for order checks in directed scenarios.
  logic [DATA_W-1:0] seen[$];
  logic [DATA_W-1:0] expq[$];

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_step();
    logic              do_pop;
    logic              do_push;
    logic              was_full;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] head;
    if (reset) begin
      m_q.delete();
      m_mode = M_COLLECT;
      m_dout = '0;
      m_vout = 1'b0;
      m_ovf  = 1'b0;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    do_pop   = (m_mode == M_DRAIN) && active && (m_q.size() > 0);
    do_push  = 1'b0;
    w        = '0;
    if (!active) begin
      do_push = recirc_valid;
      w       = recirc_in;
    end else if (m_mode != M_PASS) begin
      do_push = valid_in;
      w       = data_in;
    end
    head = (m_q.size() > 0) ? m_q[0] : '0;
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (was_full && !do_pop) m_ovf = 1'b1;
      else m_q.push_back(w);
    end
    if (m_mode == M_COLLECT) begin
      m_vout = 1'b0;
    end else if (m_mode == M_DRAIN) begin
      if (do_pop) begin
        m_dout = head;
        m_vout = 1'b1;
      end else begin
        m_vout = 1'b0;
      end
    end else begin
      m_dout = data_in;
      m_vout = valid_in;
    end
    if (!active) m_mode = M_COLLECT;
    else if (m_mode == M_COLLECT) m_mode = (m_q.size() > 0) ? M_DRAIN : M_PASS;
    else if (m_mode == M_DRAIN) m_mode = (m_q.size() == 0) ? M_PASS : M_DRAIN;
    else m_mode = M_PASS;
  endtask

  // One clock: advance the model on the edge, compare #1 later.
  task automatic tick();
    @(posedge clk_2f);
    model_step();
    #1;
    check_val("data_out",   64'(data_out),   64'(m_dout));
    check_val("valid_out",  64'(valid_out),  64'(m_vout));
    check_val("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    check_val("fifo_full",  64'(fifo_full),  64'(m_q.size() == DEPTH));
    check_val("fifo_empty", 64'(fifo_empty), 64'(m_q.size() == 0));
    check_val("overflow",   64'(overflow),   64'(m_ovf));
    if (valid_out) seen.push_back(data_out);
  endtask

  task automatic idle_inputs();
    active       = 1'b0;
    recirc_valid = 1'b0;
    valid_in     = 1'b0;
    recirc_in    = $urandom;
    data_in      = $urandom;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  task automatic compare_seen(input string tag);
    check_val({tag, "_len"}, 64'(seen.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < seen.size(); i++)
      check_val({tag, "_word"}, 64'(seen[i]), 64'(expq[i]));
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    idle_inputs();

    // 1: reset with qualifiers asserted.
    valid_in     = 1'b1;
    recirc_valid = 1'b1;
    do_reset(2);
    check_val("rst_data_out", 64'(data_out), 64'd0);
    check_val("rst_fifo_empty", 64'(fifo_empty), 64'd1);
    idle_inputs();

    // 2: three recirc words, then two fresh words as the lane activates.
    seen.delete(); expq.delete();
    for (int i = 0; i < 3; i++) begin
      w = $urandom; recirc_in = w; recirc_valid = 1'b1; expq.push_back(w);
      tick();
    end
    recirc_valid = 1'b0; active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w = $urandom; data_in = w; valid_in = 1'b1; expq.push_back(w);
      tick();
    end
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    compare_seen("s2_order");
    for (int i = 0; i < 6; i++) begin
      data_in = $urandom; valid_in = 1'($urandom_range(0, 1));
      tick();
    end

    // 3: ten recirc words into an 8-deep FIFO.
    idle_inputs();
    seen.delete(); expq.delete();
    for (int i = 0; i < 10; i++) begin
      w = $urandom; recirc_in = w; recirc_valid = 1'b1;
      if (i < DEPTH) expq.push_back(w);
      tick();
      if (i == 7) check_val("s3_full_after_8", 64'(fifo_full), 64'd1);
      if (i == 8) check_val("s3_ovf_after_9", 64'(overflow), 64'd1);
    end
    seen.delete();
    recirc_valid = 1'b0; active = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    compare_seen("s3_drain");
    check_val("s3_ovf_sticky", 64'(overflow), 64'd1);

    // 4: interrupted drain keeps the remaining backlog.
    idle_inputs();
    do_reset(1);
    seen.delete(); expq.delete();
    for (int i = 0; i < 5; i++) begin
      w = $urandom; recirc_in = w; recirc_valid = 1'b1; expq.push_back(w);
      tick();
    end
    recirc_valid = 1'b0; active = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    active = 1'b0;
    tick();
    check_val("s4_valid_drop", 64'(valid_out), 64'd0);
    check_val("s4_count_kept", 64'(fifo_count), 64'd3);
    active = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    compare_seen("s4_order");

    // 5: full FIFO in DRAIN with fresh words every cycle, across pointer wrap.
    idle_inputs();
    do_reset(1);
    seen.delete(); expq.delete();
    for (int i = 0; i < DEPTH - 1; i++) begin
      w = $urandom; recirc_in = w; recirc_valid = 1'b1; expq.push_back(w);
      tick();
    end
    recirc_valid = 1'b0; active = 1'b1;
    for (int i = 0; i < 14; i++) begin
      w = $urandom; data_in = w; valid_in = 1'b1; expq.push_back(w);
      tick();
      if (i > 0) check_val("s5_count_full", 64'(fifo_count), 64'(DEPTH));
    end
    check_val("s5_no_ovf", 64'(overflow), 64'd0);
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    compare_seen("s5_order");

    // 6: activation with empty FIFO goes straight to pass-through.
    idle_inputs();
    do_reset(1);
    active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("s6_idle_valid", 64'(valid_out), 64'd0);
    end
    for (int i = 0; i < 6; i++) begin
      w = $urandom; data_in = w; valid_in = 1'b1;
      tick();
      check_val("s6_pass_word", 64'(data_out), 64'(w));
    end

    // Random traffic, including lane toggles and mid-operation resets.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 15) == 0) active = ~active;
      recirc_in    = $urandom;
      recirc_valid = 1'($urandom_range(0, 1));
      data_in      = $urandom;
      valid_in     = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
